// File: rtl/ahb_spi_slave_pkg.sv
// Shared definitions for the AHB SPI target: register offsets, STATUS bit positions, FSM states.
package ahb_spi_slave_pkg;

    localparam logic [1:0] REG_DATA     = 2'd0;
    localparam logic [1:0] REG_STATUS   = 2'd1;
    localparam logic [1:0] REG_IRQ_MASK = 2'd2;

    localparam int BIT_RXNE    = 0;
    localparam int BIT_RXFULL  = 1;
    localparam int BIT_TXEMPTY = 2;
    localparam int BIT_TXFULL  = 3;
    localparam int BIT_BUSY    = 4;
    localparam int BIT_RXOVF   = 5;
    localparam int BIT_TXUDF   = 6;
    localparam int BIT_TXOVF   = 7;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2
    } spi_state_t;

endpackage

// File: rtl/spi_slv_fifo.sv
// Synchronous 8-bit FIFO, depth 2**AW, head visible combinationally on rdata.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module spi_slv_fifo #(
    parameter int AW = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       full,
    output logic       empty
);
    localparam int          DEPTH   = 1 << AW;
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_C);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/ahb_spi_slave.sv
// AHB-Lite SPI target (mode 0, MSB first): TX FIFO feeds MISO, received bytes queue in RX FIFO.
// SPI_SLV_IRQ_EN adds the IRQ output and the IRQ_MASK register at offset 0x8.
module ahb_spi_slave
    import ahb_spi_slave_pkg::*;
#(
    parameter int FIFO_AW = 2
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic        HREADY,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    input  logic        DCLK,
    input  logic        CS,
    input  logic        MOSI,
    output logic        MISO
`ifdef SPI_SLV_IRQ_EN
    ,
    output logic        IRQ
`endif
);
    logic [2:0] dclk_s;
    logic [2:0] cs_s;
    logic [1:0] mosi_s;
    logic       dclk_rise, dclk_fall, cs_sync, cs_fall, mosi_sync;

    logic [1:0] r_addr;
    logic       r_write, r_read;
    logic       wr_data, wr_status, rd_data;

    spi_state_t state;
    logic [7:0] tx_sh, rx_sh;
    logic [2:0] bitcnt;
    logic       active, load_evt, rx_done;

    logic       tx_push, tx_pop, tx_full, tx_empty;
    logic       rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0] tx_head, rx_head, rx_byte, tx_load_val;

    logic       rxovf, txudf, txovf;
    logic [2:0] w1c;
    logic [7:0] status;
    logic       unused_bits;

    assign HREADYOUT   = 1'b1;
    assign unused_bits = ^{HADDR[31:4], HADDR[1:0], HTRANS[0], HWDATA};

    // Two flops resynchronise; the third holds the previous value for edge detection.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dclk_s <= '0;
            cs_s   <= '1;
            mosi_s <= '0;
        end else begin
            dclk_s <= {dclk_s[1:0], DCLK};
            cs_s   <= {cs_s[1:0], CS};
            mosi_s <= {mosi_s[0], MOSI};
        end
    end

    assign dclk_rise = dclk_s[1] & ~dclk_s[2];
    assign dclk_fall = ~dclk_s[1] & dclk_s[2];
    assign cs_sync   = cs_s[1];
    assign cs_fall   = ~cs_s[1] & cs_s[2];
    assign mosi_sync = mosi_s[1];

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_addr  <= '0;
            r_write <= 1'b0;
            r_read  <= 1'b0;
        end else begin
            if (HREADY) r_addr <= HADDR[3:2];
            r_write <= HREADY & HSEL & HWRITE & HTRANS[1];
            r_read  <= HREADY & HSEL & ~HWRITE & HTRANS[1];
        end
    end

    assign wr_data   = r_write & (r_addr == REG_DATA);
    assign wr_status = r_write & (r_addr == REG_STATUS);
    assign rd_data   = r_read & (r_addr == REG_DATA);

    assign active      = (state == S_SHIFT) & ~cs_sync;
    assign load_evt    = (state == S_LOAD) | (active & dclk_fall & (bitcnt == 3'd0));
    assign rx_done     = active & dclk_rise & (bitcnt == 3'd7);
    assign rx_byte     = {rx_sh[6:0], mosi_sync};
    assign tx_load_val = tx_empty ? 8'h00 : tx_head;

    assign tx_push = wr_data;
    assign tx_pop  = load_evt & ~tx_empty;
    assign rx_push = rx_done;
    assign rx_pop  = rd_data & ~rx_empty;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state  <= S_IDLE;
            tx_sh  <= '0;
            rx_sh  <= '0;
            bitcnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cs_fall) state <= S_LOAD;
                end
                S_LOAD: begin
                    state  <= S_SHIFT;
                    tx_sh  <= tx_load_val;
                    rx_sh  <= '0;
                    bitcnt <= '0;
                end
                S_SHIFT: begin
                    if (cs_sync) begin
                        // Frame aborted or finished: partial bytes are dropped.
                        state  <= S_IDLE;
                        tx_sh  <= '0;
                        rx_sh  <= '0;
                        bitcnt <= '0;
                    end else begin
                        if (dclk_rise) begin
                            rx_sh  <= rx_byte;
                            bitcnt <= bitcnt + 3'd1;
                        end
                        if (dclk_fall) begin
                            tx_sh <= (bitcnt != 3'd0) ? {tx_sh[6:0], 1'b0} : tx_load_val;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign MISO = ~cs_sync & tx_sh[7];

    spi_slv_fifo #(.AW(FIFO_AW)) u_tx_fifo (
        .clk   (HCLK),
        .rst_n (HRESETn),
        .push  (tx_push),
        .pop   (tx_pop),
        .wdata (HWDATA[7:0]),
        .rdata (tx_head),
        .full  (tx_full),
        .empty (tx_empty)
    );

    spi_slv_fifo #(.AW(FIFO_AW)) u_rx_fifo (
        .clk   (HCLK),
        .rst_n (HRESETn),
        .push  (rx_push),
        .pop   (rx_pop),
        .wdata (rx_byte),
        .rdata (rx_head),
        .full  (rx_full),
        .empty (rx_empty)
    );

    // Sticky flags: a set in the same cycle as a write-one-to-clear wins.
    assign w1c = wr_status ? HWDATA[7:5] : 3'b000;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rxovf <= 1'b0;
            txudf <= 1'b0;
            txovf <= 1'b0;
        end else begin
            rxovf <= (rx_push & rx_full & ~rx_pop) | (rxovf & ~w1c[0]);
            txudf <= (load_evt & tx_empty)         | (txudf & ~w1c[1]);
            txovf <= (tx_push & tx_full & ~tx_pop) | (txovf & ~w1c[2]);
        end
    end

    always_comb begin
        status              = '0;
        status[BIT_RXNE]    = ~rx_empty;
        status[BIT_RXFULL]  = rx_full;
        status[BIT_TXEMPTY] = tx_empty;
        status[BIT_TXFULL]  = tx_full;
        status[BIT_BUSY]    = ~cs_sync;
        status[BIT_RXOVF]   = rxovf;
        status[BIT_TXUDF]   = txudf;
        status[BIT_TXOVF]   = txovf;
    end

`ifdef SPI_SLV_IRQ_EN
    logic [3:0] irq_mask;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            irq_mask <= '0;
            IRQ      <= 1'b0;
        end else begin
            if (r_write & (r_addr == REG_IRQ_MASK)) irq_mask <= HWDATA[3:0];
            IRQ <= |(irq_mask & {tx_empty, txudf, rxovf, ~rx_empty});
        end
    end
`endif

    always_comb begin
        HRDATA = '0;
        if (r_read) begin
            case (r_addr)
                REG_DATA:     HRDATA = rx_empty ? 32'h0 : {24'h0, rx_head};
                REG_STATUS:   HRDATA = {24'h0, status};
`ifdef SPI_SLV_IRQ_EN
                REG_IRQ_MASK: HRDATA = {28'h0, irq_mask};
`endif
                default:      HRDATA = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_spi_slave.sv
// Bench for ahb_spi_slave: register table after reset, directed SPI frames, and random ops vs a queue model.
module tb_ahb_spi_slave;
    logic        HCLK = 1'b0;
    logic        HRESETn, HSEL, HREADY, HWRITE, HREADYOUT;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [1:0]  HTRANS;
    logic        DCLK, CS, MOSI, MISO;
`ifdef SPI_SLV_IRQ_EN
    logic        IRQ;
`endif

    ahb_spi_slave #(.FIFO_AW(2)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HREADY(HREADY),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADYOUT(HREADYOUT),
        .DCLK(DCLK), .CS(CS), .MOSI(MOSI), .MISO(MISO)
`ifdef SPI_SLV_IRQ_EN
        , .IRQ(IRQ)
`endif
    );

    always #5 HCLK = ~HCLK;

    int vec  = 0;
    int errs = 0;

    // Reference model: FIFO contents as queues plus sticky flags.
    logic [7:0] m_rx[$];
    logic [7:0] m_tx[$];
    bit m_rxovf, m_txudf, m_txovf;

    typedef struct {
        bit          wr;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[19];

    function automatic logic [7:0] m_status();
        return {m_txovf, m_txudf, m_rxovf, 1'b0,
                (m_tx.size() == 4), (m_tx.size() == 0),
                (m_rx.size() == 4), (m_rx.size() != 0)};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vec++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %08h expected %08h", name, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge HCLK);
        #1;
    endtask

    task automatic ahb_wr(input logic [3:0] a, input logic [31:0] d);
        HSEL = 1'b1; HADDR = {28'h0, a}; HWRITE = 1'b1; HTRANS = 2'b10;
        wait_clk(1);
        HSEL = 1'b0; HWRITE = 1'b0; HTRANS = 2'b00; HWDATA = d;
        wait_clk(1);
    endtask

    task automatic ahb_rd(input logic [3:0] a, output logic [31:0] d);
        HSEL = 1'b1; HADDR = {28'h0, a}; HWRITE = 1'b0; HTRANS = 2'b10;
        wait_clk(1);
        HSEL = 1'b0; HTRANS = 2'b00;
        d = HRDATA;
        wait_clk(1);
    endtask

    task automatic spi_xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            MOSI = mo[7-i];
            wait_clk(5);
            DCLK = 1'b1;
            mi[7-i] = MISO;
            wait_clk(5);
            DCLK = 1'b0;
        end
    endtask

    task automatic m_tx_take(output logic [7:0] b);
        if (m_tx.size() > 0) b = m_tx.pop_front();
        else begin b = 8'h00; m_txudf = 1'b1; end
    endtask

    task automatic m_wr_data(input logic [7:0] b);
        ahb_wr(4'h0, {$urandom_range(0, 255), 16'h0, b});
        if (m_tx.size() < 4) m_tx.push_back(b);
        else m_txovf = 1'b1;
    endtask

    task automatic m_rd_data(input string name);
        logic [31:0] d;
        logic [31:0] e;
        ahb_rd(4'h0, d);
        e = (m_rx.size() > 0) ? {24'h0, m_rx.pop_front()} : 32'h0;
        check(name, d, e);
    endtask

    task automatic m_rd_status(input string name);
        logic [31:0] d;
        ahb_rd(4'h4, d);
        check(name, d, {24'h0, m_status()});
    endtask

    task automatic m_w1c(input logic [7:0] b);
        ahb_wr(4'h4, {24'h0, b});
        if (b[5]) m_rxovf = 1'b0;
        if (b[6]) m_txudf = 1'b0;
        if (b[7]) m_txovf = 1'b0;
    endtask

    // Each completed byte (and the frame start) consumes one TX entry.
    task automatic m_frame(input int n, input bit use_first, input logic [7:0] first, input string name);
        logic [7:0] exp_mi, mo, mi;
        CS = 1'b0;
        wait_clk(10);
        m_tx_take(exp_mi);
        for (int k = 0; k < n; k++) begin
            mo = (use_first && k == 0) ? first : 8'($urandom);
            spi_xfer(mo, 8, mi);
            check($sformatf("%s_miso%0d", name, k), {24'h0, mi}, {24'h0, exp_mi});
            if (m_rx.size() < 4) m_rx.push_back(mo);
            else m_rxovf = 1'b1;
            m_tx_take(exp_mi);
        end
        wait_clk(5);
        CS = 1'b1;
        wait_clk(10);
    endtask

    task automatic do_reset();
        HRESETn = 1'b0;
        wait_clk(3);
        check("rst_hrdata", HRDATA, 32'h0);
        check("rst_hreadyout", {31'h0, HREADYOUT}, 32'h1);
        check("rst_miso", {31'h0, MISO}, 32'h0);
        HRESETn = 1'b1;
        wait_clk(3);
        m_rx.delete(); m_tx.delete();
        m_rxovf = 1'b0; m_txudf = 1'b0; m_txovf = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        logic [7:0]  mi, e8;

        HRESETn = 1'b0; HSEL = 1'b0; HREADY = 1'b1; HADDR = '0; HTRANS = '0;
        HWRITE = 1'b0; HWDATA = '0; DCLK = 1'b0; CS = 1'b1; MOSI = 1'b0;

        tbl[0]  = '{1'b0, 4'h4, 32'h0,        32'h04};
        tbl[1]  = '{1'b0, 4'h0, 32'h0,        32'h00};
        tbl[2]  = '{1'b0, 4'hC, 32'h0,        32'h00};
        tbl[3]  = '{1'b1, 4'h8, 32'h0000_00F0, 32'h0};
        tbl[4]  = '{1'b0, 4'h8, 32'h0,        32'h00};
        tbl[5]  = '{1'b1, 4'hC, 32'hFFFF_FFFF, 32'h0};
        tbl[6]  = '{1'b0, 4'hC, 32'h0,        32'h00};
        tbl[7]  = '{1'b1, 4'h0, 32'hFFFF_FF11, 32'h0};
        tbl[8]  = '{1'b0, 4'h4, 32'h0,        32'h00};
        tbl[9]  = '{1'b1, 4'h0, 32'h0000_0022, 32'h0};
        tbl[10] = '{1'b1, 4'h0, 32'h0000_0033, 32'h0};
        tbl[11] = '{1'b1, 4'h0, 32'h0000_0044, 32'h0};
        tbl[12] = '{1'b0, 4'h4, 32'h0,        32'h08};
        tbl[13] = '{1'b1, 4'h0, 32'h0000_0055, 32'h0};
        tbl[14] = '{1'b0, 4'h4, 32'h0,        32'h88};
        tbl[15] = '{1'b1, 4'h4, 32'h0000_0080, 32'h0};
        tbl[16] = '{1'b0, 4'h4, 32'h0,        32'h08};
        tbl[17] = '{1'b1, 4'h4, 32'h0000_001F, 32'h0};
        tbl[18] = '{1'b0, 4'h4, 32'h0,        32'h08};

        wait_clk(2);
        do_reset();

        // Register table from a fresh reset.
        for (int i = 0; i < 19; i++) begin
            if (tbl[i].wr) ahb_wr(tbl[i].addr, tbl[i].wdata);
            else begin
                ahb_rd(tbl[i].addr, d);
                check($sformatf("tbl%0d", i), d, tbl[i].exp);
            end
        end
        m_tx = '{8'h11, 8'h22, 8'h33, 8'h44};
        m_frame(2, 1'b0, 8'h00, "tblframe");
        m_rd_status("tblframe_status");
        m_rd_data("tblframe_rx0");
        m_rd_data("tblframe_rx1");

        // Single byte exchange: 0xA5 out on MISO, 0x3C in.
        do_reset();
        m_wr_data(8'hA5);
        m_frame(1, 1'b1, 8'h3C, "basic");
        m_rd_status("basic_status");
        m_rd_data("basic_rx");
        m_rd_status("basic_status2");

        // RX overflow with depth 4, then W1C of RXOVF.
        do_reset();
        m_frame(5, 1'b0, 8'h00, "rxovf");
        m_rd_status("rxovf_status");
        m_w1c(8'h20);
        m_rd_status("rxovf_w1c");
        for (int i = 0; i < 4; i++) m_rd_data($sformatf("rxovf_rx%0d", i));
        m_rd_status("rxovf_drained");

        // TX underflow frame, then overfill TX.
        do_reset();
        m_frame(1, 1'b0, 8'h00, "txudf");
        m_rd_status("txudf_status");
        for (int i = 0; i < 5; i++) m_wr_data(8'(i + 1));
        m_rd_status("txovf_status");

        // CS raised after 3 bits, then a full frame.
        do_reset();
        m_wr_data(8'h81);
        m_wr_data(8'h7E);
        CS = 1'b0;
        wait_clk(10);
        m_tx_take(e8);
        spi_xfer(8'hE0, 3, mi);
        check("partial_miso", {29'h0, mi[7:5]}, {29'h0, e8[7:5]});
        wait_clk(5);
        CS = 1'b1;
        wait_clk(10);
        m_rd_status("partial_status");
        m_frame(1, 1'b1, 8'hC3, "after_partial");
        m_rd_data("after_partial_rx");

        // Reset pulse in the middle of a byte.
        m_wr_data(8'hFF);
        CS = 1'b0;
        wait_clk(10);
        spi_xfer(8'hAA, 3, mi);
        MOSI = 1'b1;
        HRESETn = 1'b0;
        #2;
        check("midrst_miso", {31'h0, MISO}, 32'h0);
        CS = 1'b1;
        DCLK = 1'b0;
        wait_clk(3);
        HRESETn = 1'b1;
        wait_clk(5);
        m_rx.delete(); m_tx.delete();
        m_rxovf = 1'b0; m_txudf = 1'b0; m_txovf = 1'b0;
        m_rd_status("midrst_status");
        m_rd_data("midrst_rx");

        // Random operation mix against the model.
        do_reset();
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 4))
                0: m_wr_data(8'($urandom));
                1: m_rd_data($sformatf("rnd%0d_rx", it));
                2: m_rd_status($sformatf("rnd%0d_status", it));
                3: m_w1c(8'($urandom));
                default: m_frame($urandom_range(1, 3), 1'b0, 8'h00, $sformatf("rnd%0d", it));
            endcase
        end
        m_rd_status("rnd_final_status");

`ifdef SPI_SLV_IRQ_EN
        do_reset();
        ahb_wr(4'h8, 32'h1);
        ahb_rd(4'h8, d);
        check("irq_mask_rb", d, 32'h1);
        check("irq_idle", {31'h0, IRQ}, 32'h0);
        m_frame(1, 1'b1, 8'h5A, "irq");
        wait_clk(2);
        check("irq_set", {31'h0, IRQ}, 32'h1);
        m_rd_data("irq_rx");
        wait_clk(1);
        check("irq_clear", {31'h0, IRQ}, 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
